// File: rtl/id_hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-GPR pending-write counters drive the
// zero-latency stall/issue decision, with writeback bypass and perf/err status.
module id_hazard_scoreboard #(
    parameter int unsigned CNT_W    = 2,
    parameter int unsigned MAX_PEND = 3,
    parameter int unsigned STALL_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic               id_use_rs,
    input  logic               id_use_rt,
    input  logic               id_reg_write,
    input  logic [4:0]         id_wr_addr,
    input  logic               id_flush,
    input  logic               wb_valid,
    input  logic [4:0]         wb_addr,
    output logic               id_stall,
    output logic               id_issue,
    output logic [31:0]        busy_vec,
    output logic [STALL_W-1:0] stall_cnt,
    output logic               wb_err
);

    localparam int unsigned NREG  = 32;
    localparam int unsigned EFF_W = CNT_W + 1;

    logic [NREG-1:0][CNT_W-1:0] cnt_q;
    logic [NREG-1:0][CNT_W-1:0] cnt_d;
    logic [NREG-1:0]            inc_vec;
    logic [NREG-1:0]            dec_vec;
    logic [NREG-1:0]            busy_d;

    logic rs_wb_hit;
    logic rt_wb_hit;
    logic wa_wb_hit;
    logic rs_haz;
    logic rt_haz;
    logic dest_full;
    logic hazard;
    logic live;
    logic wb_err_set;

    // Writeback in the same cycle retires one pending write (write-through RF).
    assign rs_wb_hit = wb_valid && (wb_addr == id_rs);
    assign rt_wb_hit = wb_valid && (wb_addr == id_rt);
    assign wa_wb_hit = wb_valid && (wb_addr == id_wr_addr);

    // eff(s) > 0  <=>  cnt[s] > bypass hit
    assign rs_haz = id_use_rs && (id_rs != 5'd0) &&
                    (cnt_q[id_rs] > CNT_W'(rs_wb_hit));
    assign rt_haz = id_use_rt && (id_rt != 5'd0) &&
                    (cnt_q[id_rt] > CNT_W'(rt_wb_hit));

    // eff(dest) >= MAX_PEND, widened by one bit so MAX_PEND + 1 cannot wrap
    assign dest_full = id_reg_write && (id_wr_addr != 5'd0) &&
                       (EFF_W'(cnt_q[id_wr_addr]) >=
                        (EFF_W'(MAX_PEND) + EFF_W'(wa_wb_hit)));

    assign hazard = rs_haz || rt_haz || dest_full;
    assign live   = rst_n && id_valid && !id_flush;

    assign id_stall = live && hazard;
    assign id_issue = live && !hazard;

    assign wb_err_set = wb_valid && (wb_addr != 5'd0) && (cnt_q[wb_addr] == '0);

    // One-hot increment/decrement requests; register 0 is never tracked.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (id_issue && id_reg_write && (id_wr_addr != 5'd0)) begin
            inc_vec[id_wr_addr] = 1'b1;
        end
        if (wb_valid && (wb_addr != 5'd0) && (cnt_q[wb_addr] != '0)) begin
            dec_vec[wb_addr] = 1'b1;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        busy_d = '0;
        for (int r = 0; r < 32; r++) begin
            cnt_d[r]  = cnt_q[r] + CNT_W'(inc_vec[r]) - CNT_W'(dec_vec[r]);
            busy_d[r] = (cnt_d[r] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            busy_vec <= '0;
        end else begin
            cnt_q    <= cnt_d;
            busy_vec <= busy_d;
        end
    end

    // Saturating stall-cycle counter for performance monitoring.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (id_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_err <= 1'b0;
        end else if (wb_err_set) begin
            wb_err <= 1'b1;
        end
    end

endmodule

// File: doc/id_hazard_scoreboard.md
Name: id_hazard_scoreboard

Overview:
- Issue controller for the instruction-decode stage.
- Keeps a per-register count of in-flight writes for all 32 GPRs.
- Stalls ID when a source register (rs/rt) still has an outstanding write, or when the destination's pending count is saturated.
- Sits between the decoder and the register file. Retires pending writes on the writeback strobe and exposes a stall-cycle counter for performance monitoring.

Parameters:
- CNT_W, 2, width of each per-register pending counter.
- MAX_PEND, 3, maximum outstanding writes per register; must be ≤ 2^CNT_W − 1.
- STALL_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  decoded instruction present in ID.
- id_rs  input  5  source register A.
- id_rt  input  5  source register B.
- id_use_rs  input  1  instruction reads rs.
- id_use_rt  input  1  instruction reads rt.
- id_reg_write  input  1  instruction writes a GPR (RegWrite).
- id_wr_addr  input  5  destination register (mux output of rt/rd per RegDst).
- id_flush  input  1  kill the ID instruction this cycle.
- wb_valid  input  1  writeback retiring a write this cycle.
- wb_addr  input  5  register being written back.
- id_stall  output  1  hold ID/IF this cycle (combinational).
- id_issue  output  1  instruction leaves ID this cycle (combinational).
- busy_vec  output  32  bit i = register i has pending count > 0 (registered).
- stall_cnt  output  STALL_W  saturating count of stall cycles.
- wb_err  output  1  sticky: writeback to a register with count 0.

Behaviour:
- Reset (async, rst_n=0):
  - all pending counters = 0.
  - busy_vec = 0, stall_cnt = 0, wb_err = 0.
  - id_stall and id_issue evaluate to 0 while in reset.
- Register 0:
  - Never pending.
  - Issue or writeback with address 0 leaves the counter unchanged; sources equal to 0 never cause a stall.
- Effective pending for a source register s (same-cycle WB bypass; the register file is write-through):
  - eff(s) = cnt[s] − (wb_valid && wb_addr==s ? 1 : 0), evaluated on pre-edge values.
  - Source hazard = eff(s) > 0.
- WAW limit: dest_full = id_reg_write && id_wr_addr≠0 && eff(id_wr_addr) ≥ MAX_PEND.
- Stall and issue:
  - id_stall = id_valid && !id_flush && ((id_use_rs && eff(id_rs)>0) || (id_use_rt && eff(id_rt)>0) || dest_full).
  - id_issue = id_valid && !id_flush && !id_stall.
  - Zero-cycle decision; the scoreboard adds no latency to a clean issue.
- Counter update at each rising edge, for each register r ≠ 0:
  - cnt[r] += (id_issue && id_reg_write && id_wr_addr==r).
  - cnt[r] −= (wb_valid && wb_addr==r && cnt[r]>0).
  - Increment and decrement in the same cycle on the same r leave cnt[r] unchanged.
- wb_err: set when wb_valid && wb_addr≠0 && cnt[wb_addr]==0. The counter stays at 0. Cleared only by reset.
- busy_vec[r] = (cnt[r] ≠ 0), updated from the new counter values (registered, one cycle after the edge).
- stall_cnt increments by 1 at each edge where id_stall=1 and saturates at all-ones.
- Flush:
  - id_flush suppresses stall and issue for that cycle; counters are not incremented for the killed instruction.
  - Outstanding writes still retire normally.
- Reset asserted mid-stall: everything clears immediately. Any later writebacks of pre-reset writes set wb_err (intended diagnostic).
- Each stall/issue decision depends only on current inputs and registered counters; no internal FSM beyond the counters.

Test Plan:
- Reset, then issue "add $3" (id_reg_write=1, wr_addr=3) → id_issue=1; next cycle busy_vec=0x0000_0008. wb_valid, wb_addr=3 → busy_vec=0 the following cycle, wb_err=0.
- Load-use stall: issue a write to $5; next cycle id_rs=5, id_use_rs=1 → id_stall=1 for 3 cycles and stall_cnt=3. On the cycle wb_addr=5 (bypass), id_stall=0 and id_issue=1.
- WAW saturation: three issues writing $7 with no writeback → cnt=3. A fourth write to $7 → id_stall=1. The same cycle with wb_valid, wb_addr=7 → issue proceeds and cnt stays 3.
- Register 0: issue a write to $0, then read rs=0 → no stall and busy_vec[0]=0. wb_addr=0 → wb_err stays 0.
- Flush: a hazarded instruction with id_flush=1 → id_stall=0, id_issue=0, stall_cnt unchanged, no counter change.
- Error and reset: wb_valid, wb_addr=9 with cnt[9]=0 → wb_err=1 and it stays set. Drop rst_n mid-stall → all outputs 0 asynchronously, before the next clk edge.
